alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares the single 4-bit ALU between two requesters, for example the front-panel operand/opcode controller and an automatic self-test sequencer. It accepts one operation at a time from either requester, drives the ALU operand, carry-in and opcode inputs from registers, and captures the ALU result one cycle later. It returns the result to the winning requester with a done pulse. It sits between the requesters and the combinational ALU, and it never decodes the opcode.

## Interface
Parameters:
- WIDTH, 4, operand/result width
- OPW, 4, opcode width

Ports:
- clk  in  1  system clock, rising edge
- reset_signal  in  1  synchronous, active-high reset
- req0 / req1  in  1  operation request from requester 0 / 1
- a0, b0 / a1, b1  in  WIDTH  operands for requester 0 / 1
- cin0 / cin1  in  1  carry-in for requester 0 / 1
- op0 / op1  in  OPW  opcode for requester 0 / 1, passed through opaque
- ack0 / ack1  out  1  one-cycle pulse: request accepted, operands latched
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_cin  out  1  registered ALU carry-in
- alu_op  out  OPW  registered ALU opcode
- alu_out  in  WIDTH  ALU result (combinational from alu_*)
- alu_cout  in  1  ALU carry-out
- res  out  WIDTH  captured result, held until the next capture
- res_cout  out  1  captured carry-out
- done0 / done1  out  1  one-cycle pulse: res/res_cout valid for requester 0 / 1
- busy  out  1  high while in EXEC
- owner  out  1  index of the requester currently or last served

## Operation
- FSM with two states: IDLE, EXEC.
- IDLE, no req: hold. alu_*, res, res_cout and owner keep their values.
- IDLE, any req: pick the winner n (rules below). At the edge:
  - alu_a/b/cin/op <= a_n/b_n/cin_n/op_n
  - ack_n <= 1, owner <= n, state <= EXEC
- EXEC: req inputs are ignored. At the edge:
  - res <= alu_out, res_cout <= alu_cout
  - done_owner <= 1, last <= owner, state <= IDLE
- Winner selection:
  - One req high: that requester wins.
  - Both high: round-robin. The winner is the requester that is not `last`.
  - After reset, last = 1, so requester 0 wins the first tie.
- Requester rule: req is sampled only in IDLE. A requester must drop req by the edge that follows its ack. A req still high when the FSM returns to IDLE is a new operation.
- Operand and opcode inputs need only be stable at the granting edge.
- No width extension: res is exactly alu_out (WIDTH bits); overflow shows only as res_cout.
- Reset, including mid-EXEC:
  - State <= IDLE, last <= 1.
  - All outputs <= 0: ack*, done*, busy, owner, alu_*, res, res_cout.
  - An in-flight operation is dropped with no done pulse.

## Timing
- Edge k, IDLE with req_n high: ack_n and busy are high for the cycle k..k+1. alu_* are valid from edge k.
- Edge k+1: result captured. done_n is high for the cycle k+1..k+2. res is valid from edge k+1 and held.
- Edge k+2: earliest next grant.
  - Latency: request sample to done = 1 cycle.
  - Throughput: 1 operation per 2 cycles.
- ack and done never assert for both requesters in the same cycle. ack and done never assert in the same cycle.
- The ALU path from alu_* to alu_out must settle within one clock period.

## Structure
- Shared package alu_pkg holds:
  - WIDTH and OPW defaults
  - IDLE/EXEC state encoding
  - Requester index constants REQ0 = 0, REQ1 = 1
- One natural sub-module: rr_pick2. It is a combinational 2-way round-robin picker with inputs req0, req1, last and outputs grant_valid, grant_idx. It is reused by future multi-client blocks.
- All state and output registers live in alu_arbiter.

## Test plan
The bench ALU stub returns {alu_cout, alu_out} = alu_a + alu_b + alu_cin for every opcode.
- Reset sequence: hold reset_signal for 2 cycles, then release.
  - During reset and after release: every output is 0 and busy is 0.
- Single requester: req0 with a0=4'b1111, b0=4'b0001, cin0=1, op0=4'b1100 for one cycle.
  - ack0 pulses one cycle later. alu_op = 4'b1100.
  - done0 pulses one cycle after ack0, with res = 4'b0001 and res_cout = 1.
- Tie after reset: req0 and req1 both held high.
  - Grants alternate 0, 1, 0, 1, one grant every 2 cycles.
  - Each done pulse matches its owner's operands, e.g. a1=3, b1=4, cin1=0 gives res=7 and res_cout=0.
- Ignore during EXEC: req1 rises in the EXEC cycle of a req0 operation.
  - No ack1 until the FSM returns to IDLE. req1 is then granted at the next edge.
- Reset mid-operation: assert reset_signal in the EXEC cycle.
  - No done pulse. res = 0 and state = IDLE. The next tie grants requester 0.
- Hold behaviour: no requests for 10 cycles after a completed operation.
  - res, res_cout, owner and alu_* stay unchanged. ack* and done* stay 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, FSM encoding and requester indices.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_OPW   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that was not last served wins.
module rr_pick2
  import alu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = REQ0;
    if (req0 && req1) begin
      grant_idx = ~last;
    end else if (req1) begin
      grant_idx = REQ1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: latch operands on grant,
// capture the result one cycle later and return it with a done pulse.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned OPW   = DEF_OPW
) (
  input  logic             clk,
  input  logic             reset_signal,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] res,
  output logic             res_cout,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             owner
);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_cout_q, res_cout_d;

  logic grant_valid;
  logic grant_idx;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state and output logic; pulses default low, everything else holds.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cin_d  = alu_cin_q;
    alu_op_d   = alu_op_q;
    res_d      = res_q;
    res_cout_d = res_cout_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          busy_d  = 1'b1;
          state_d = EXEC;
          if (grant_idx == REQ1) begin
            alu_a_d   = a1;
            alu_b_d   = b1;
            alu_cin_d = cin1;
            alu_op_d  = op1;
            ack1_d    = 1'b1;
          end else begin
            alu_a_d   = a0;
            alu_b_d   = b0;
            alu_cin_d = cin0;
            alu_op_d  = op0;
            ack0_d    = 1'b1;
          end
        end
      end
      EXEC: begin
        res_d      = alu_out;
        res_cout_d = alu_cout;
        done0_d    = (owner_q == REQ0);
        done1_d    = (owner_q == REQ1);
        last_d     = owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight operation; last starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset_signal) begin
      state_q    <= IDLE;
      last_q     <= REQ1;
      owner_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
      alu_op_q   <= '0;
      res_q      <= '0;
      res_cout_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cin_q  <= alu_cin_d;
      alu_op_q   <= alu_op_d;
      res_q      <= res_d;
      res_cout_q <= res_cout_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_cin  = alu_cin_q;
  assign alu_op   = alu_op_q;
  assign res      = res_q;
  assign res_cout = res_cout_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an adder ALU stub (a + b + cin for every opcode).
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset_signal;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       cin0, cin1;
  logic [3:0] op0, op1;
  logic       ack0, ack1;
  logic [3:0] alu_a, alu_b;
  logic       alu_cin;
  logic [3:0] alu_op;
  logic [3:0] alu_out;
  logic       alu_cout;
  logic [3:0] res;
  logic       res_cout;
  logic       done0, done1;
  logic       busy;
  logic       owner;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign {alu_cout, alu_out} = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);

  alu_arbiter dut (
    .clk          (clk),
    .reset_signal (reset_signal),
    .req0         (req0),
    .req1         (req1),
    .a0           (a0),
    .b0           (b0),
    .a1           (a1),
    .b1           (b1),
    .cin0         (cin0),
    .cin1         (cin1),
    .op0          (op0),
    .op1          (op1),
    .ack0         (ack0),
    .ack1         (ack1),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_cout     (alu_cout),
    .res          (res),
    .res_cout     (res_cout),
    .done0        (done0),
    .done1        (done1),
    .busy         (busy),
    .owner        (owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, ".ack0"}, ack0, 1'b0);
    chk1({tag, ".ack1"}, ack1, 1'b0);
    chk1({tag, ".done0"}, done0, 1'b0);
    chk1({tag, ".done1"}, done1, 1'b0);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".owner"}, owner, 1'b0);
    chk4({tag, ".alu_a"}, alu_a, 4'h0);
    chk4({tag, ".alu_b"}, alu_b, 4'h0);
    chk1({tag, ".alu_cin"}, alu_cin, 1'b0);
    chk4({tag, ".alu_op"}, alu_op, 4'h0);
    chk4({tag, ".res"}, res, 4'h0);
    chk1({tag, ".res_cout"}, res_cout, 1'b0);
  endtask

  initial begin
    logic       exp_idx;
    logic [4:0] exp_sum;

    reset_signal = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'h0; b0 = 4'h0; cin0 = 1'b0; op0 = 4'h0;
    a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0; op1 = 4'h0;

    // Reset held for two cycles, then released
    tick();
    chk_all_zero("rst1");
    tick();
    chk_all_zero("rst2");
    reset_signal = 1'b0;
    tick();
    chk_all_zero("post_rst");

    // Single requester 0: 15 + 1 + 1 = 0x11
    req0 = 1'b1; a0 = 4'hF; b0 = 4'h1; cin0 = 1'b1; op0 = 4'hC;
    tick();
    req0 = 1'b0;
    chk1("single.ack0", ack0, 1'b1);
    chk1("single.ack1", ack1, 1'b0);
    chk1("single.busy", busy, 1'b1);
    chk1("single.done0_early", done0, 1'b0);
    chk4("single.alu_op", alu_op, 4'hC);
    chk4("single.alu_a", alu_a, 4'hF);
    chk1("single.owner", owner, 1'b0);
    tick();
    chk1("single.done0", done0, 1'b1);
    chk1("single.ack0_low", ack0, 1'b0);
    chk1("single.busy_low", busy, 1'b0);
    chk4("single.res", res, 4'h1);
    chk1("single.res_cout", res_cout, 1'b1);

    // Hold: ten idle cycles keep every captured value
    for (int i = 0; i < 10; i++) begin
      tick();
      chk4("hold.res", res, 4'h1);
      chk1("hold.res_cout", res_cout, 1'b1);
      chk1("hold.owner", owner, 1'b0);
      chk4("hold.alu_a", alu_a, 4'hF);
      chk4("hold.alu_b", alu_b, 4'h1);
      chk1("hold.alu_cin", alu_cin, 1'b1);
      chk4("hold.alu_op", alu_op, 4'hC);
      chk4("hold.pulses", {ack0, ack1, done0, done1}, 4'h0);
      chk1("hold.busy", busy, 1'b0);
    end

    // Reset in the EXEC cycle of a requester 1 operation (last is 0 here)
    req1 = 1'b1; a1 = 4'h9; b1 = 4'h9; cin1 = 1'b0; op1 = 4'h3;
    tick();
    req1 = 1'b0;
    chk1("midrst.ack1", ack1, 1'b1);
    chk1("midrst.owner", owner, 1'b1);
    reset_signal = 1'b1;
    tick();
    chk_all_zero("midrst.in");
    reset_signal = 1'b0;
    tick();
    chk_all_zero("midrst.after");

    // Tie: grants alternate 0,1,0,1 starting from requester 0 after reset
    req0 = 1'b1; req1 = 1'b1;
    b0 = 4'h6; cin0 = 1'b1; op0 = 4'h1;
    b1 = 4'h4; cin1 = 1'b0; op1 = 4'h2;
    for (int k = 0; k < 4; k++) begin
      exp_idx = 1'(k % 2);
      a0 = 4'(k);
      a1 = (k == 3) ? 4'hE : 4'h3;
      cin1 = (k == 3);
      tick();
      chk1("tie.ack0", ack0, !exp_idx);
      chk1("tie.ack1", ack1, exp_idx);
      chk1("tie.owner", owner, exp_idx);
      chk4("tie.alu_op", alu_op, exp_idx ? 4'h2 : 4'h1);
      exp_sum = exp_idx ? (5'(a1) + 5'(b1) + 5'(cin1)) : (5'(a0) + 5'(b0) + 5'(cin0));
      tick();
      chk1("tie.done0", done0, !exp_idx);
      chk1("tie.done1", done1, exp_idx);
      chk4("tie.acks_low", {2'b00, ack0, ack1}, 4'h0);
      chk4("tie.res", res, exp_sum[3:0]);
      chk1("tie.res_cout", res_cout, exp_sum[4]);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // req1 raised during EXEC of a requester 0 op is held off until IDLE
    req0 = 1'b1; a0 = 4'h2; b0 = 4'h3; cin0 = 1'b0; op0 = 4'h5;
    tick();
    req0 = 1'b0;
    chk1("ign.ack0", ack0, 1'b1);
    req1 = 1'b1; a1 = 4'h3; b1 = 4'h4; cin1 = 1'b0; op1 = 4'h9;
    tick();
    chk1("ign.done0", done0, 1'b1);
    chk1("ign.no_ack1", ack1, 1'b0);
    chk4("ign.res0", res, 4'h5);
    tick();
    req1 = 1'b0;
    chk1("ign.ack1", ack1, 1'b1);
    chk1("ign.owner", owner, 1'b1);
    chk4("ign.alu_a", alu_a, 4'h3);
    chk4("ign.alu_op", alu_op, 4'h9);
    tick();
    chk1("ign.done1", done1, 1'b1);
    chk1("ign.done0_low", done0, 1'b0);
    chk4("ign.res1", res, 4'h7);
    chk1("ign.res_cout", res_cout, 1'b0);
    tick();
    chk4("ign.quiet", {ack0, ack1, done0, done1}, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
